// File: rtl/nanov_spi_ram_responder_if.sv
// SPI pin bundle between the nanoV SPI initiator and the RAM responder.
// The initiator drives SCK, CS and MOSI. The responder drives MISO.
interface nanov_spi_ram_responder_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/nanov_spi_ram_responder.sv
// SPI RAM target for the nanoV core. It decodes READ (0x03) and WRITE (0x02) commands
// against an internal byte array. SCK is oversampled in the clk domain.
//
// state        | meaning
// S_IDLE       | CS inactive, MISO held low
// S_CMD        | shifting in the 8-bit command byte
// S_ADDR       | shifting in the 24-bit address, only the low ADDR_BITS are kept
// S_DATA_READ  | presenting mem bytes on MISO, auto-incrementing
// S_DATA_WRITE | collecting MOSI bytes and committing them, auto-incrementing
// S_IGNORE     | unsupported command, wait for CS to rise
module nanov_spi_ram_responder #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  nanov_spi_ram_responder_if.slave spi,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA_READ,
    S_DATA_WRITE,
    S_IGNORE
  } state_t;

  localparam int         MEM_DEPTH = 1 << ADDR_BITS;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Bit 0 is the metastability stage and bit 1 the synchronized value.
  // For SCK, bit 2 holds the previous synchronized value, used for edge detection.
  logic [2:0] sck_pipe_q, sck_pipe_d;
  logic [1:0] cs_pipe_q, cs_pipe_d;
  logic [1:0] mosi_pipe_q, mosi_pipe_d;

  state_t               state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 op_read_q, op_read_d;
  logic                 miso_q, miso_d;
  logic                 cmd_err_q, cmd_err_d;

  logic [7:0] mem_q [MEM_DEPTH];

  logic                 sck_rise, sck_fall, cs_sync, mosi_sync;
  logic [7:0]           shift_in;
  logic [ADDR_BITS-1:0] addr_shift, addr_inc;
  logic [7:0]           rd_byte, next_byte;
  logic [2:0]           rd_bit_idx;
  logic                 spi_we;

  always_comb begin
    sck_pipe_d  = {sck_pipe_q[1:0], spi.spi_sck};
    cs_pipe_d   = {cs_pipe_q[0], spi.spi_cs_n};
    mosi_pipe_d = {mosi_pipe_q[0], spi.spi_mosi};
  end

  assign sck_rise  = sck_pipe_q[1] & ~sck_pipe_q[2];
  assign sck_fall  = ~sck_pipe_q[1] & sck_pipe_q[2];
  assign cs_sync   = cs_pipe_q[1];
  assign mosi_sync = mosi_pipe_q[1];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    op_read_d  = op_read_q;
    miso_d     = miso_q;
    cmd_err_d  = 1'b0;
    spi_we     = 1'b0;
    shift_in   = {shift_q, mosi_sync};
    addr_shift = {addr_q[ADDR_BITS-2:0], mosi_sync};
    addr_inc   = addr_q + ADDR_BITS'(1);
    rd_byte    = mem_q[addr_q];
    next_byte  = mem_q[addr_inc];
    // For a bit count k of 1 to 7, the bit to present next is 7-k, which equals ~k in 3 bits.
    rd_bit_idx = ~bit_cnt_q[2:0];

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (!cs_sync) begin
          state_d   = S_CMD;
          bit_cnt_d = 5'd0;
          shift_d   = 7'd0;
        end
      end

      S_CMD: begin
        if (sck_rise) begin
          shift_d = shift_in[6:0];
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            if (shift_in == CMD_READ) begin
              state_d   = S_ADDR;
              op_read_d = 1'b1;
            end else if (shift_in == CMD_WRITE) begin
              state_d   = S_ADDR;
              op_read_d = 1'b0;
            end else begin
              state_d   = S_IGNORE;
              cmd_err_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      S_ADDR: begin
        if (sck_rise) begin
          addr_d = addr_shift;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = 5'd0;
            if (op_read_q) begin
              state_d = S_DATA_READ;
              miso_d  = mem_q[addr_shift][7];
            end else begin
              state_d = S_DATA_WRITE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      S_DATA_READ: begin
        // Count 0 means the first bit is already on MISO and no rise has happened yet.
        // Count 8 means the byte is done and the next fall moves to the next address.
        if (sck_rise && bit_cnt_q != 5'd8) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (sck_fall) begin
          if (bit_cnt_q == 5'd8) begin
            addr_d    = addr_inc;
            bit_cnt_d = 5'd0;
            miso_d    = next_byte[7];
          end else if (bit_cnt_q != 5'd0) begin
            miso_d = rd_byte[rd_bit_idx];
          end
        end
      end

      S_DATA_WRITE: begin
        if (sck_rise) begin
          shift_d = shift_in[6:0];
          if (bit_cnt_q == 5'd7) begin
            spi_we    = 1'b1;
            addr_d    = addr_inc;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      S_IGNORE: begin
        miso_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // CS deassertion aborts whatever is in flight and discards any partial byte.
    if (state_q != S_IDLE && cs_sync) begin
      state_d   = S_IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = 5'd0;
      shift_d   = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_pipe_q  <= 3'b000;
      cs_pipe_q   <= 2'b11;
      mosi_pipe_q <= 2'b00;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 7'd0;
      addr_q      <= '0;
      op_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      sck_pipe_q  <= sck_pipe_d;
      cs_pipe_q   <= cs_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      op_read_q   <= op_read_d;
      miso_q      <= miso_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // The SPI write port comes second, so it takes priority when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
    if (spi_we) begin
      mem_q[addr_q] <= shift_in;
    end
  end

  assign spi.spi_miso = miso_q;
  assign busy         = (state_q != S_IDLE);
  assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_nanov_spi_ram_responder.sv
// Self-checking bench for nanov_spi_ram_responder. It drives SPI at SCK = clk/8 and checks
// MISO bytes against an expected-data queue.
module tb_nanov_spi_ram_responder;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       busy;
  logic       cmd_err;

  nanov_spi_ram_responder_if spi_if ();

  nanov_spi_ram_responder #(.ADDR_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi_if),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_pulses = 0;
  logic [7:0] exp_q [$];

  always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    int          n;
    logic [23:0] data;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic spi_bit(input logic mo, output logic mi);
    spi_if.spi_mosi = mo;
    repeat (4) @(negedge clk);
    mi = spi_if.spi_miso;
    spi_if.spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    spi_if.spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], m);
      r[i] = m;
    end
  endtask

  task automatic cs_low();
    spi_if.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_if.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] r;
    send_byte(cmd, r);
    send_byte(a[23:16], r);
    send_byte(a[15:8], r);
    send_byte(a[7:0], r);
  endtask

  task automatic spi_read(input logic [23:0] a, input int n, input logic [23:0] d);
    logic [7:0] r;
    logic [7:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(d[23-8*i -: 8]);
    cs_low();
    send_header(8'h03, a);
    for (int i = 0; i < n; i++) begin
      send_byte(8'h00, r);
      e = exp_q.pop_front();
      check("read_data", {24'd0, r}, {24'd0, e});
      check("busy_in_read", {31'd0, busy}, 32'd1);
    end
    cs_high();
  endtask

  task automatic spi_write(input logic [23:0] a, input int n, input logic [23:0] d);
    logic [7:0] r;
    cs_low();
    send_header(8'h02, a);
    for (int i = 0; i < n; i++) send_byte(d[23-8*i -: 8], r);
    cs_high();
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] acc;
    logic       m;
    int         err_before;

    tbl[0] = '{1'b1, 24'h0000FE, 3, 24'h112233};
    tbl[1] = '{1'b0, 24'h0000FE, 3, 24'h112233};
    tbl[2] = '{1'b0, 24'h000000, 1, 24'h330000};
    tbl[3] = '{1'b0, 24'hABCD10, 1, 24'hA50000};
    tbl[4] = '{1'b1, 24'h000080, 2, 24'hC0DE00};
    tbl[5] = '{1'b0, 24'h00007F, 3, 24'h3CC0DE};

    rst = 1'b1;
    load_en = 1'b0;
    load_addr = 8'h00;
    load_data = 8'h00;
    spi_if.spi_sck  = 1'b0;
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso", {31'd0, spi_if.spi_miso}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cmd_err", {31'd0, cmd_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    backdoor(8'h10, 8'hA5);
    backdoor(8'h21, 8'hC3);
    backdoor(8'h7F, 8'h3C);

    // First read, with the busy rise and fall timing checked around CS.
    cs_low();
    check("busy_after_cs_low", {31'd0, busy}, 32'd1);
    send_header(8'h03, 24'h000010);
    send_byte(8'h00, r);
    check("first_read", {24'd0, r}, 32'h000000A5);
    repeat (4) @(negedge clk);
    spi_if.spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_at_cs_detect", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_after_cs_high", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].wr) spi_write(tbl[i].addr, tbl[i].n, tbl[i].data);
      else           spi_read(tbl[i].addr, tbl[i].n, tbl[i].data);
    end

    // Partial byte: 0x5A is committed, and the 5-bit tail is discarded.
    cs_low();
    send_header(8'h02, 24'h000020);
    send_byte(8'h5A, r);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    cs_high();
    spi_read(24'h000020, 2, 24'h5AC300);

    // Bad command: one cmd_err pulse, then MISO stays silent.
    err_before = err_pulses;
    acc = 8'h00;
    cs_low();
    send_byte(8'h9F, r);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hFF, r);
      acc = acc | r;
    end
    cs_high();
    check("cmd_err_pulses", err_pulses - err_before, 32'd1);
    check("ignore_miso", {24'd0, acc}, 32'd0);
    spi_read(24'h000010, 1, 24'hA50000);

    // Collision: the backdoor load lands on the same clk as the SPI commit of 0x77 to 0x40.
    cs_low();
    send_header(8'h02, 24'h000040);
    for (int i = 7; i >= 1; i--) spi_bit(((8'h77 >> i) & 8'h01) != 8'h00, m);
    spi_if.spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    spi_if.spi_sck = 1'b1;
    repeat (2) @(negedge clk);
    load_addr = 8'h40;
    load_data = 8'hEE;
    load_en   = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    spi_if.spi_sck = 1'b0;
    cs_high();
    spi_read(24'h000040, 1, 24'h770000);

    // Reset in the middle of the third data bit of a read.
    cs_low();
    send_header(8'h03, 24'h000010);
    spi_bit(1'b0, m);
    spi_bit(1'b0, m);
    spi_if.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("third_bit_before_rst", {31'd0, spi_if.spi_miso}, 32'd1);
    spi_if.spi_sck = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_miso", {31'd0, spi_if.spi_miso}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_cmd_err", {31'd0, cmd_err}, 32'd0);
    spi_if.spi_sck  = 1'b0;
    spi_if.spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    spi_read(24'h000010, 1, 24'hA50000);

    check("total_cmd_err_pulses", err_pulses, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nanov_spi_ram_responder.md
# nanoV_spi_ram_responder

SPI RAM target for the nanoV bit-serial core, implementing the far end of the core's SPI memory bus. It decodes READ (0x03) and WRITE (0x02) transactions issued by the core's SPI initiator, serves data from an internal byte array, and commits written bytes. SCK is oversampled in the system clock domain. The block is used as the memory model in core-level benches and as on-chip scratch RAM.

## Interface
- ADDR_BITS, default 8: byte-address width of the internal array (2^ADDR_BITS bytes).
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- spi_sck  input  1  SPI clock from the initiator, asynchronous to clk, mode 0.
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  serial data from the initiator, MSB first.
- spi_miso  output  1  serial data to the initiator, MSB first; driven 0 when not sending.
- load_en  input  1  backdoor byte write strobe used by the bench and boot preload.
- load_addr  input  ADDR_BITS  backdoor write address.
- load_data  input  8  backdoor write data.
- busy  output  1  high while CS is asserted and the FSM is not IDLE.
- cmd_err  output  1  one-clk pulse when an unsupported command byte completes.

## Operation
- spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer. Rise and fall of SCK are detected from the synchronized value and its previous value.
- MOSI is sampled on the detected SCK rise. MISO changes only on the detected SCK fall, or on entry to DATA_READ (see below).
- FSM states:
  - IDLE: waits for synchronized CS low, then goes to CMD with bit counter = 0.
  - CMD: shifts 8 bits. On the 8th bit: 0x03 goes to ADDR with op = read; 0x02 goes to ADDR with op = write; any other value pulses cmd_err and goes to IGNORE.
  - ADDR: shifts 24 bits. Only the low ADDR_BITS are kept; upper bits are ignored, not checked. On the 24th bit the FSM goes to DATA_READ or DATA_WRITE.
  - DATA_READ: on entry, spi_miso = bit 7 of mem[addr]. Each following SCK fall presents the next bit. After the fall that follows the 8th rise of a byte, addr increments and bit 7 of the new byte is presented.
  - DATA_WRITE: shifts MOSI bits. On each 8th rise, the byte is written to mem[addr] and addr increments.
  - IGNORE: holds spi_miso = 0 until CS rises.
- From any state, synchronized CS high returns the FSM to IDLE on the next clk. A partial write byte is discarded, a partial read is abandoned, and spi_miso = 0.
- Address arithmetic is modulo 2^ADDR_BITS, so auto-increment wraps from the top address to 0.
- Backdoor load: when load_en is high, mem[load_addr] = load_data on that clk. If the same clk also commits an SPI write to the same address, the SPI write wins.
- Memory contents are not affected by rst.

## Timing
- Reset values: FSM = IDLE, spi_miso = 0, busy = 0, cmd_err = 0, bit counter = 0, shift registers = 0.
- Input latency: a pin edge is acted on 3 clk after it settles (2 sync stages + edge register).
- spi_miso updates within 1 clk of a detected SCK fall. In absolute terms, that is ≤ 4 clk after the pin fall.
- Requirements on the initiator: SCK high ≥ 4 clk and SCK low ≥ 4 clk. CS low setup ≥ 4 clk before the first SCK rise. CS held after the last SCK fall ≥ 4 clk.
- A transaction that meets these rules sees read data valid at every SCK rise, including the first data bit, which is presented on entry to DATA_READ.
- The write commit is visible to the backdoor and to a later read transaction 1 clk after the detected 8th rise.
- cmd_err is exactly 1 clk wide.
- busy rises 1 clk after CS low is detected and falls 1 clk after CS high is detected.

## Test plan
- Reset: preload mem[0x10] = 0xA5. Send READ 0x03, addr 0x000010 at SCK = clk/8. MISO returns 1010_0101; busy is high throughout and low 1 clk after CS rises.
- Burst write then read: WRITE 0x02, addr 0x0000FE, data 0x11 0x22 0x33. Afterwards mem[0xFE] = 0x11, mem[0xFF] = 0x22, mem[0x00] = 0x33 (wrap). A READ at 0xFE returns 11 22 33.
- Partial byte: WRITE at addr 0x20 with 0x5A sent in full, then CS raised after 5 bits of the next byte. mem[0x20] = 0x5A and mem[0x21] keeps its preloaded value.
- Bad command: send 0x9F. cmd_err pulses once and MISO stays 0 through 32 further SCKs. The next READ at 0x10 works normally.
- Upper-address ignore plus collision: READ at 0xABCD10 returns mem[0x10]. A backdoor load to 0x40 in the same clk as an SPI commit of 0x77 to 0x40 leaves mem[0x40] = 0x77.
- Reset mid-read: assert rst during the 3rd data bit. All outputs return to their reset values and the FSM is in IDLE. After CS cycles, a new READ works.
